// File: rtl/regfile_p.sv
// regfile_p: parameterised register file with one write port, two registered
// read ports with write-to-read bypass, optional hardwired-zero entry 0, and a
// clear sweep that zeroes every entry one per cycle while busy is high.

module regfile_p #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rda_addr,
    input  logic [ADDR_W-1:0] rdb_addr,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy
);

    // Last entry visited by the clear sweep; the sweep ends after zeroing it.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam bit                ZERO_EN  = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_next_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_a_r;
    logic [DATA_W-1:0] rd_b_r;
    logic [DATA_W-1:0] rd_a_next_s;
    logic [DATA_W-1:0] rd_b_next_s;
    logic              busy_r;
    logic              clearing_s;
    logic              last_idx_s;
    logic              wr_commit_s;

    // True when the address refers to the hardwired-zero entry.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_EN && (addr == {ADDR_W{1'b0}});
    endfunction

    // Read-port result for one address: zero while sweeping or for the
    // hardwired entry, the incoming write data on an address match, else the
    // stored entry.
    function automatic logic [DATA_W-1:0] port_value(
        input logic              sweeping,
        input logic [ADDR_W-1:0] raddr,
        input logic              commit,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (sweeping) begin
            val = {DATA_W{1'b0}};
        end else if (is_zero_reg(raddr)) begin
            val = {DATA_W{1'b0}};
        end else if (commit && (raddr == waddr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Decode of the current cycle: sweep activity, sweep end, write commit.
    always_comb begin
        clearing_s  = (state_r == ST_CLEAR);
        last_idx_s  = (idx_r == LAST_IDX);
        wr_commit_s = wr_en && !clearing_s && !is_zero_reg(wr_addr);
    end

    // Next-state and sweep-index logic for the IDLE/CLEAR controller.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next_s = ST_CLEAR;
                    idx_next_s   = {ADDR_W{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                    idx_next_s   = idx_r;
                end
            end
            ST_CLEAR: begin
                // clr_req is deliberately not looked at here: no restart.
                if (last_idx_s) begin
                    state_next_s = ST_IDLE;
                    idx_next_s   = {ADDR_W{1'b0}};
                end else begin
                    state_next_s = ST_CLEAR;
                    idx_next_s   = idx_r + ADDR_W'(1'b1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Next values of both read ports, including same-edge write bypass.
    always_comb begin
        rd_a_next_s = port_value(clearing_s, rda_addr, wr_commit_s, wr_addr,
                                 wr_data, mem_r[rda_addr]);
        rd_b_next_s = port_value(clearing_s, rdb_addr, wr_commit_s, wr_addr,
                                 wr_data, mem_r[rdb_addr]);
    end

    // Controller state, sweep index and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            busy_r  <= (state_next_s == ST_CLEAR);
        end
    end

    // Storage array: sweep zeroing takes priority, writes are dropped while
    // sweeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (clearing_s) begin
            mem_r[idx_r] <= {DATA_W{1'b0}};
        end else if (wr_commit_s) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    // Registered read outputs, one cycle after the address is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_r <= {DATA_W{1'b0}};
            rd_b_r <= {DATA_W{1'b0}};
        end else begin
            rd_a_r <= rd_a_next_s;
            rd_b_r <= rd_b_next_s;
        end
    end

    assign rd_data_a = rd_a_r;
    assign rd_data_b = rd_b_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_regfile_p.sv
// Scoreboard testbench for regfile_p: two instances (DEPTH=4/ZERO_REG=0 and
// DEPTH=8/ZERO_REG=1) share one stimulus stream; a behavioural model pushes
// expected outputs per edge and a monitor pops and compares after each edge.

module tb_regfile_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rda_addr;
    logic [2:0] rdb_addr;
    logic       clr_req;

    logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic       busy0, busy1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Model state: entry contents and remaining sweep cycles per instance.
    logic [7:0] m_mem [2][8];
    int         m_rem [2];

    regfile_p #(.DATA_W(8), .DEPTH(4), .ZERO_REG(0)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[1:0]),
        .wr_data(wr_data), .rda_addr(rda_addr[1:0]), .rdb_addr(rdb_addr[1:0]),
        .clr_req(clr_req), .rd_data_a(rd_a0), .rd_data_b(rd_b0), .busy(busy0)
    );

    regfile_p #(.DATA_W(8), .DEPTH(8), .ZERO_REG(1)) dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rda_addr(rda_addr), .rdb_addr(rdb_addr),
        .clr_req(clr_req), .rd_data_a(rd_a1), .rd_data_b(rd_b1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Behavioural model of one edge for instance k (0: depth 4, 1: depth 8 zero-reg).
    function automatic exp_t model_step(input int k, input logic r, input logic we,
                                        input int wa_in, input logic [7:0] wd,
                                        input int ra_in, input int rb_in, input logic clr);
        int   d, wa, ra, rb;
        bit   z, commit;
        exp_t e;
        d  = (k == 0) ? 4 : 8;
        z  = (k == 1);
        wa = wa_in % d;
        ra = ra_in % d;
        rb = rb_in % d;
        e  = '0;
        if (r) begin
            for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
            m_rem[k] = 0;
        end else if (m_rem[k] > 0) begin
            m_mem[k][d - m_rem[k]] = 8'h00;
            m_rem[k] = m_rem[k] - 1;
        end else begin
            commit = we && !(z && wa == 0);
            e.a = (z && ra == 0) ? 8'h00 : ((commit && ra == wa) ? wd : m_mem[k][ra]);
            e.b = (z && rb == 0) ? 8'h00 : ((commit && rb == wa) ? wd : m_mem[k][rb]);
            if (commit) m_mem[k][wa] = wd;
            if (clr) m_rem[k] = d;
        end
        e.busy = (m_rem[k] > 0);
        return e;
    endfunction

    // Drive one cycle of inputs, record expectations, advance past the edge.
    task automatic step(input logic r, input logic we, input logic [2:0] wa,
                        input logic [7:0] wd, input logic [2:0] ra,
                        input logic [2:0] rb, input logic clr);
        rst      = r;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rda_addr = ra;
        rdb_addr = rb;
        clr_req  = clr;
        q0.push_back(model_step(0, r, we, int'(wa), wd, int'(ra), int'(rb), clr));
        q1.push_back(model_step(1, r, we, int'(wa), wd, int'(ra), int'(rb), clr));
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs against queued expectations after each edge.
    exp_t e0_m, e1_m;
    always @(posedge clk) begin
        #1;
        if (q0.size() != 0) begin
            e0_m = q0.pop_front();
            chk("sb4_rd_a", {24'h0, rd_a0}, {24'h0, e0_m.a});
            chk("sb4_rd_b", {24'h0, rd_b0}, {24'h0, e0_m.b});
            chk("sb4_busy", {31'h0, busy0}, {31'h0, e0_m.busy});
        end
        if (q1.size() != 0) begin
            e1_m = q1.pop_front();
            chk("sb8_rd_a", {24'h0, rd_a1}, {24'h0, e1_m.a});
            chk("sb8_rd_b", {24'h0, rd_b1}, {24'h0, e1_m.b});
            chk("sb8_busy", {31'h0, busy1}, {31'h0, e1_m.busy});
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic       r_r, we_r, clr_r;
        logic [2:0] wa_r, ra_r, rb_r;
        logic [7:0] wd_r;
        int         busy_cycles;

        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0;
            for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
        end
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
        rda_addr = 3'd0; rdb_addr = 3'd0; clr_req = 1'b0;
        #1;
        chk("reset_rd_a", {24'h0, rd_a0}, 32'h0);
        chk("reset_rd_b", {24'h0, rd_b0}, 32'h0);
        chk("reset_busy", {31'h0, busy0}, 32'h0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);

        // Write then read with one-cycle latency.
        step(1'b0, 1'b1, 3'd2, 8'hA5, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd1, 1'b0);
        chk("wr_rd_a", {24'h0, rd_a0}, 32'hA5);
        chk("wr_rd_b", {24'h0, rd_b0}, 32'h00);

        // Same-edge bypass on both ports.
        step(1'b0, 1'b1, 3'd3, 8'h3C, 3'd3, 3'd3, 1'b0);
        chk("bypass_a", {24'h0, rd_a0}, 32'h3C);
        chk("bypass_b", {24'h0, rd_b0}, 32'h3C);

        // Fill, clear sweep with dropped writes, then all zero.
        step(1'b0, 1'b1, 3'd0, 8'h11, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd1, 8'h22, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'h33, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd3, 8'h44, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);
        chk("clr_busy0", {31'h0, busy0}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'(i), 8'hFF, 3'd1, 3'd2, 1'b1);
            chk("clr_busy_mid", {31'h0, busy0}, 32'h1);
        end
        step(1'b0, 1'b1, 3'd3, 8'hFF, 3'd3, 3'd3, 1'b0);
        chk("clr_busy_end", {31'h0, busy0}, 32'h0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 1'b0);
        chk("clr_zero_0", {24'h0, rd_a0}, 32'h0);
        chk("clr_zero_1", {24'h0, rd_b0}, 32'h0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0);
        chk("clr_zero_2", {24'h0, rd_a0}, 32'h0);
        chk("clr_zero_3", {24'h0, rd_b0}, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);

        // Clear request together with a write.
        step(1'b0, 1'b1, 3'd1, 8'h77, 3'd1, 3'd0, 1'b1);
        chk("clrwr_bypass", {24'h0, rd_a0}, 32'h77);
        chk("clrwr_busy", {31'h0, busy0}, 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 1'b0);
        chk("clrwr_swept", {24'h0, rd_a0}, 32'h0);

        // Reset in the middle of a sweep.
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_busy4", {31'h0, busy0}, 32'h0);
        chk("midrst_busy8", {31'h0, busy1}, 32'h0);
        chk("midrst_rd_a", {24'h0, rd_a0}, 32'h0);
        chk("midrst_rd_b", {24'h0, rd_b0}, 32'h0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd0, 8'h5A, 3'd0, 3'd0, 1'b0);
        chk("midrst_bypass", {24'h0, rd_a0}, 32'h5A);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        chk("midrst_read", {24'h0, rd_a0}, 32'h5A);

        // Depth 8 with hardwired zero entry.
        step(1'b0, 1'b1, 3'd0, 8'hEE, 3'd0, 3'd0, 1'b0);
        chk("zr_bypass0", {24'h0, rd_a1}, 32'h0);
        step(1'b0, 1'b1, 3'd7, 8'hEE, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b0);
        chk("zr_read0", {24'h0, rd_a1}, 32'h0);
        chk("zr_read7", {24'h0, rd_b1}, 32'hEE);
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, (i == 0));
            if (busy1) busy_cycles++;
        end
        chk("zr_busy_len", busy_cycles, 32'd8);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r_r   = ($urandom_range(0, 63) == 0);
            we_r  = 1'($urandom_range(0, 1));
            wa_r  = 3'($urandom);
            wd_r  = 8'($urandom);
            ra_r  = 3'($urandom);
            rb_r  = ($urandom_range(0, 3) == 0) ? ra_r : 3'($urandom);
            clr_r = ($urandom_range(0, 15) == 0);
            step(r_r, we_r, wa_r, wd_r, ra_r, rb_r, clr_r);
        end

        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        chk("sb_drained", q0.size() + q1.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_p.md
REGFILE_P -- requirements
Module: regfile_p

Interface
REQ-001 Parameter DATA_W, default 8, entry width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of entries (power of two, >=2).
REQ-003 Parameter ZERO_REG, default 0, 1 = entry 0 hardwired to zero.
REQ-004 Derived ADDR_W = clog2(DEPTH); not user-overridable.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 wr_en  in  1  write request for this cycle.
REQ-008 wr_addr  in  ADDR_W  write entry index.
REQ-009 wr_data  in  DATA_W  write data.
REQ-010 rda_addr  in  ADDR_W  read port A index.
REQ-011 rdb_addr  in  ADDR_W  read port B index.
REQ-012 clr_req  in  1  request a full-array clear sweep.
REQ-013 rd_data_a  out  DATA_W  registered read result, port A.
REQ-014 rd_data_b  out  DATA_W  registered read result, port B.
REQ-015 busy  out  1  registered; high while clear sweep is in progress.

Function
REQ-016 Write: on a rising edge with wr_en=1 and busy=0, entry[wr_addr] SHALL take wr_data; otherwise the entry is unchanged.
REQ-017 Read latency: rd_data_a/b SHALL update on every rising edge with the value addressed by rda_addr/rdb_addr sampled at that edge (1-cycle latency).
REQ-018 Bypass: if the same edge commits a write and a read address equals wr_addr, that port SHALL return wr_data (new value), not the old entry.
REQ-019 Both ports SHALL read the same address concurrently without interference.
REQ-020 ZERO_REG=1: writes to entry 0 SHALL be discarded, reads of entry 0 SHALL return 0, and bypass SHALL NOT apply to address 0.
REQ-021 FSM states: IDLE and CLEAR; busy=1 exactly when state is CLEAR.
REQ-022 IDLE -> CLEAR on an edge with clr_req=1; sweep index loads 0.
REQ-023 In CLEAR, each edge SHALL zero entry[index] and increment index; after entry DEPTH-1 is zeroed, the FSM SHALL return to IDLE; busy high for exactly DEPTH cycles.
REQ-024 clr_req while busy=1 SHALL be ignored (no restart, no extension).
REQ-025 wr_en while busy=1 SHALL be ignored and dropped (no queuing).
REQ-026 Reads whose edge is sampled while busy=1 SHALL return 0 on both ports.
REQ-027 Simultaneous clr_req=1 and wr_en=1 in IDLE: the write commits and bypass applies on that edge; the sweep subsequently zeroes the written entry.
REQ-028 Index counter SHALL be ADDR_W bits; terminal detection on index = DEPTH-1, no wrap beyond one sweep.

Reset
REQ-029 While rst=1: all entries 0, rd_data_a=0, rd_data_b=0, busy=0, state IDLE, index 0, independent of clk.
REQ-030 rst asserted mid-sweep SHALL abort the sweep immediately; first edge after release behaves as IDLE.
REQ-031 No write or clear SHALL occur on the edge at which rst is high.

Verification (DATA_W=8, DEPTH=4, ZERO_REG=0 unless stated)
REQ-032 Write 0xA5 to addr 2, next cycle read A=2 -> rd_data_a=0xA5 one edge later; B=1 -> 0x00.
REQ-033 wr_en=1, wr_addr=3, wr_data=0x3C, rda_addr=rdb_addr=3 same cycle -> both ports 0x3C after that edge.
REQ-034 Fill entries 0..3 with 0x11,0x22,0x33,0x44, pulse clr_req -> busy high 4 cycles, writes of 0xFF during busy dropped, afterwards all entries read 0x00.
REQ-035 clr_req with wr_en (addr 1, 0x77) in IDLE -> read of addr 1 returns 0x77 that edge; after sweep addr 1 reads 0x00.
REQ-036 Assert rst two cycles into a sweep -> busy=0 immediately, all outputs 0; subsequent write/read of addr 0 with 0x5A returns 0x5A.
REQ-037 DEPTH=8, ZERO_REG=1: write 0xEE to addr 0 and addr 7 -> addr 0 reads 0x00, addr 7 reads 0xEE; clr_req -> busy high 8 cycles.
